dm_stage: RTL

//  Data memory plus M/W pipeline boundary for the P6 five-stage MIPS core. It executes sb/sh/sw

---
 rtl/dm_pkg.sv | 6 +
 rtl/dm_lane_gen.sv | 31 +++
 rtl/dm_stage.sv | 67 ++++++
 3 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared encodings for the M/W data-memory stage and the W-stage load extender
package dm_pkg;
  typedef enum logic [1:0] {SOP_NONE = 2'd0, SOP_SB = 2'd1, SOP_SH = 2'd2, SOP_SW = 2'd3} store_op_e;
  typedef enum logic [2:0] {EXT_WORD = 3'd0, EXT_LBU = 3'd1, EXT_LB = 3'd2, EXT_LHU = 3'd3, EXT_LH = 3'd4} ext_e;
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;
endpackage

// File: rtl/dm_lane_gen.sv
// dm_lane_gen: byte-enable, aligned store data and misalignment detect for one M-stage access
//   in : store_op_i (sb/sh/sw), ext_i (load size code), load_i, addr_i (byte offset), wdata_i
//   out: be_o (lanes to write, zero when misaligned), wdata_o (data replicated to lanes), misalign_o
module dm_lane_gen
  import dm_pkg::*;
(
  input  logic [1:0]  store_op_i,
  input  logic [2:0]  ext_i,
  input  logic        load_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o
);
  logic       st_mis;
  logic       ld_mis;
  logic [3:0] be_raw;
  always_comb begin
    st_mis = (store_op_i == SOP_SH && addr_i[0]) || (store_op_i == SOP_SW && addr_i != 2'd0);
    ld_mis = load_i && ((ext_i == EXT_WORD && addr_i != 2'd0) ||
                        ((ext_i == EXT_LHU || ext_i == EXT_LH) && addr_i[0]));
    be_raw = store_op_i == SOP_SB ? 4'b0001 << addr_i :
             store_op_i == SOP_SH ? (addr_i[1] ? 4'b1100 : 4'b0011) :
             store_op_i == SOP_SW ? 4'b1111 : 4'b0000;
    be_o = st_mis ? 4'b0000 : be_raw;
    wdata_o = store_op_i == SOP_SB ? {4{wdata_i[7:0]}} :
              store_op_i == SOP_SH ? {2{wdata_i[15:0]}} : wdata_i;
    misalign_o = st_mis || ld_mis;
  end
endmodule

// File: rtl/dm_stage.sv
// dm_stage: data memory with byte-lane stores, M/W pipeline registers and post-reset zeroing
//   in : clk, reset (async active-low), addr_m, wdata_m, store_op_m, ext_option_m, load_m
//   out: stall_m (high while zeroing), dmout_w, aluout_w, ext_option_w, misalign_w (W registers)
module dm_stage
  import dm_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  input  logic [1:0]  store_op_m,
  input  logic [2:0]  ext_option_m,
  input  logic        load_m,
  output logic        stall_m,
  output logic [31:0] dmout_w,
  output logic [31:0] aluout_w,
  output logic [2:0]  ext_option_w,
  output logic        misalign_w
);
  logic [31:0]           mem [2**ADDR_WIDTH];
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_q, clr_d, idx;
  logic [3:0]            be;
  logic [31:0]           wdata_al;
  logic                  misalign;
  dm_lane_gen u_lane (
    .store_op_i (store_op_m),
    .ext_i      (ext_option_m),
    .load_i     (load_m),
    .addr_i     (addr_m[1:0]),
    .wdata_i    (wdata_m),
    .be_o       (be),
    .wdata_o    (wdata_al),
    .misalign_o (misalign)
  );
  assign stall_m = state_q == CLEAR;
  assign idx     = addr_m[ADDR_WIDTH+1:2];
  // the counter wraps to zero on the last clear write, so RUN always starts with clr_q == 0
  always_comb begin
    clr_d   = stall_m ? clr_q + 1'b1 : clr_q;
    state_d = stall_m && clr_q == '1 ? RUN : state_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= CLEAR;
      clr_q        <= '0;
      dmout_w      <= '0;
      aluout_w     <= '0;
      ext_option_w <= '0;
      misalign_w   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_q        <= clr_d;
      dmout_w      <= stall_m ? '0 : mem[idx];
      aluout_w     <= stall_m ? '0 : addr_m;
      ext_option_w <= stall_m ? '0 : ext_option_m;
      misalign_w   <= stall_m ? 1'b0 : misalign;
    end
  end
  // array has no reset; the CLEAR sequencer zeroes it word by word instead
  always_ff @(posedge clk) begin
    if (stall_m) mem[clr_q] <= '0;
    else for (int b = 0; b < 4; b++) if (be[b]) mem[idx][8*b +: 8] <= wdata_al[8*b +: 8];
  end
endmodule
